// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint sequencer for the single-cycle MIPS core: drives cpu_en/cpu_rst and counts executed instructions.
// Optional cycle limit (max_cyc input) is compiled in with `define CPU_RUN_CTRL_MAXCYC_EN.
module cpu_run_ctrl #(
    parameter int PC_W       = 32,
    parameter int CNT_W      = 32,
    parameter int RST_CYCLES = 4
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    input  logic [2:0]       pro_sel,
`ifdef CPU_RUN_CTRL_MAXCYC_EN
    input  logic [CNT_W-1:0] max_cyc,
`endif
    output logic             cpu_rst,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic [2:0]       pro_sel_q,
    output logic [CNT_W-1:0] cycle_cnt
);

    // state    | meaning
    // S_RSTSEQ | core held in reset for RST_CYCLES cycles
    // S_HALT   | core frozen, waiting for step/run
    // S_RUN    | free-run until breakpoint, limit or halt_req
    // S_STEP   | one enabled cycle, then back to HALT
    typedef enum logic [1:0] {
        S_RSTSEQ = 2'd0,
        S_HALT   = 2'd1,
        S_RUN    = 2'd2,
        S_STEP   = 2'd3
    } state_e;

    localparam int              RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RST_CYCLES - 1);

    state_e           state_q, state_d;
    logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [2:0]       pro_sel_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic             resume_q, resume_d;
    logic             cpu_rst_q, cpu_rst_d;

    logic pro_chg;
    logic bp_match;
    logic lim_reached;
    logic bp_hit;

    always_comb begin
        pro_chg  = (state_q != S_RSTSEQ) && (pro_sel != pro_sel_q);
        bp_match = bp_en && (pc == bp_addr) && !resume_q;
`ifdef CPU_RUN_CTRL_MAXCYC_EN
        lim_reached = (max_cyc != '0) && (cycle_cnt_q == max_cyc);
`else
        lim_reached = 1'b0;
`endif
        bp_hit = (state_q == S_RUN) && (bp_match || lim_reached);
        cpu_en = !pro_chg && (((state_q == S_RUN) && !bp_hit) || (state_q == S_STEP));
    end

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        pro_sel_d = pro_sel_q;
        resume_d  = resume_q;
        if (pro_chg) begin
            // a new program always restarts the core, whatever else is pending
            state_d   = S_RSTSEQ;
            rst_cnt_d = RC_LOAD;
            pro_sel_d = pro_sel;
            resume_d  = 1'b0;
        end else begin
            case (state_q)
                S_RSTSEQ: begin
                    if (pro_sel != pro_sel_q) begin
                        pro_sel_d = pro_sel;
                        rst_cnt_d = RC_LOAD;
                    end else if (rst_cnt_q == '0) begin
                        state_d = S_HALT;
                    end else begin
                        rst_cnt_d = rst_cnt_q - RC_W'(1);
                    end
                end
                S_HALT: begin
                    if (!halt_req) begin
                        if (step_req) begin
                            state_d = S_STEP;
                        end else if (run_req && !lim_reached) begin
                            state_d  = S_RUN;
                            resume_d = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    resume_d = 1'b0;
                    if (bp_hit || halt_req) begin
                        state_d = S_HALT;
                    end
                end
                default: begin
                    state_d = S_HALT;
                end
            endcase
        end
        cycle_cnt_d = (state_d == S_RSTSEQ) ? '0 : cycle_cnt_q + CNT_W'(cpu_en);
        cpu_rst_d   = (state_d == S_RSTSEQ);
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q     <= S_RSTSEQ;
            rst_cnt_q   <= RC_LOAD;
            pro_sel_q   <= pro_sel;
            cycle_cnt_q <= '0;
            resume_q    <= 1'b0;
            cpu_rst_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            pro_sel_q   <= pro_sel_d;
            cycle_cnt_q <= cycle_cnt_d;
            resume_q    <= resume_d;
            cpu_rst_q   <= cpu_rst_d;
        end
    end

    assign cpu_rst   = cpu_rst_q;
    assign state     = state_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: a cycle model queues expected outputs, directed tasks add fixed-value checks.
module tb_cpu_run_ctrl;
    localparam int PC_W       = 32;
    localparam int CNT_W      = 32;
    localparam int RST_CYCLES = 4;

    logic             clk;
    logic             RST;
    logic             run_req, halt_req, step_req, bp_en;
    logic [PC_W-1:0]  bp_addr, pc;
    logic [2:0]       pro_sel;
    logic             cpu_rst, cpu_en;
    logic [1:0]       state;
    logic [2:0]       pro_sel_q;
    logic [CNT_W-1:0] cycle_cnt;
`ifdef CPU_RUN_CTRL_MAXCYC_EN
    logic [CNT_W-1:0] max_cyc;
    initial max_cyc = '0;
`endif

    cpu_run_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES)) dut (
        .clk(clk), .RST(RST),
        .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .pro_sel(pro_sel),
`ifdef CPU_RUN_CTRL_MAXCYC_EN
        .max_cyc(max_cyc),
`endif
        .cpu_rst(cpu_rst), .cpu_en(cpu_en), .state(state),
        .pro_sel_q(pro_sel_q), .cycle_cnt(cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]       st;
        logic             en;
        logic             rst;
        logic [2:0]       psq;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0]       m_state;
    int               m_rc;
    logic [2:0]       m_psq;
    logic [CNT_W-1:0] m_cnt;
    bit               m_res;
    bit               m_valid = 1'b0;

    logic [1:0]       s_state;
    logic             s_en, s_rst;
    logic [2:0]       s_psq;
    logic [CNT_W-1:0] s_cnt;

    // One clock: predict this cycle's outputs, sample DUT, advance the model across the edge.
    task automatic tick();
        exp_t             e, g;
        bit               chg, bp;
        logic [1:0]       ns;
        int               nrc;
        logic [2:0]       npsq;
        logic [CNT_W-1:0] ncnt;
        bit               nres;
        chg   = (m_state != 2'd0) && (pro_sel != m_psq);
        bp    = (m_state == 2'd2) && bp_en && (pc == bp_addr) && !m_res;
        e.st  = m_state;
        e.en  = !chg && (((m_state == 2'd2) && !bp) || (m_state == 2'd3));
        e.rst = (m_state == 2'd0);
        e.psq = m_psq;
        e.cnt = m_cnt;
        if (m_valid) sb.push_back(e);
        #1;
        s_state = state; s_en = cpu_en; s_rst = cpu_rst; s_psq = pro_sel_q; s_cnt = cycle_cnt;
        if (m_valid && sb.size() > 0) begin
            g = sb.pop_front();
            n_checks++;
            if (state !== g.st) begin n_errors++; $display("FAIL sb_state: got %0d expected %0d at %0t", state, g.st, $time); end
            n_checks++;
            if (cpu_en !== g.en) begin n_errors++; $display("FAIL sb_cpu_en: got %0b expected %0b at %0t", cpu_en, g.en, $time); end
            n_checks++;
            if (cpu_rst !== g.rst) begin n_errors++; $display("FAIL sb_cpu_rst: got %0b expected %0b at %0t", cpu_rst, g.rst, $time); end
            n_checks++;
            if (pro_sel_q !== g.psq) begin n_errors++; $display("FAIL sb_pro_sel_q: got %0d expected %0d at %0t", pro_sel_q, g.psq, $time); end
            n_checks++;
            if (cycle_cnt !== g.cnt) begin n_errors++; $display("FAIL sb_cycle_cnt: got %0d expected %0d at %0t", cycle_cnt, g.cnt, $time); end
        end
        ns = m_state; nrc = m_rc; npsq = m_psq; ncnt = m_cnt; nres = m_res;
        if (RST) begin
            ns = 2'd0; nrc = 0; npsq = pro_sel; ncnt = '0; nres = 1'b0;
        end else begin
            if (chg) begin
                ns = 2'd0; nrc = 0; npsq = pro_sel; nres = 1'b0;
            end else begin
                case (m_state)
                    2'd0: begin
                        if (pro_sel != m_psq) begin npsq = pro_sel; nrc = 0; end
                        else if (m_rc == RST_CYCLES - 1) ns = 2'd1;
                        else nrc = m_rc + 1;
                    end
                    2'd1: begin
                        if (!halt_req && step_req) ns = 2'd3;
                        else if (!halt_req && run_req) begin ns = 2'd2; nres = 1'b1; end
                    end
                    2'd2: begin
                        nres = 1'b0;
                        if (bp || halt_req) ns = 2'd1;
                    end
                    default: ns = 2'd1;
                endcase
            end
            if (ns == 2'd0) ncnt = '0;
            else if (e.en) ncnt = m_cnt + 1;
        end
        @(posedge clk);
        m_state = ns; m_rc = nrc; m_psq = npsq; m_cnt = ncnt; m_res = nres;
        if (RST) m_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        for (int i = 0; i < RST_CYCLES; i++) begin
            tick();
            n_checks++;
            if (s_rst !== 1'b1 || s_state !== 2'd0) begin
                n_errors++; $display("FAIL reset_hold: cyc %0d cpu_rst %0b state %0d, required 1 and 0", i, s_rst, s_state);
            end
        end
        tick();
        n_checks++;
        if (s_state !== 2'd1) begin n_errors++; $display("FAIL reset_to_halt: state %0d required 1", s_state); end
        n_checks++;
        if (s_rst !== 1'b0 || s_en !== 1'b0) begin n_errors++; $display("FAIL reset_outputs: cpu_rst %0b cpu_en %0b required 0 0", s_rst, s_en); end
        n_checks++;
        if (s_cnt !== '0) begin n_errors++; $display("FAIL reset_cnt: cycle_cnt %0d required 0", s_cnt); end
    endtask

    task automatic test_step();
        for (int k = 1; k <= 2; k++) begin
            step_req = 1'b1;
            tick();
            step_req = 1'b0;
            tick();
            n_checks++;
            if (s_state !== 2'd3 || s_en !== 1'b1) begin
                n_errors++; $display("FAIL step_active: state %0d cpu_en %0b required 3 1", s_state, s_en);
            end
            tick();
            n_checks++;
            if (s_state !== 2'd1 || s_cnt !== CNT_W'(k)) begin
                n_errors++; $display("FAIL step_done: state %0d cycle_cnt %0d required 1 %0d", s_state, s_cnt, k);
            end
        end
    endtask

    task automatic test_run_halt();
        logic [CNT_W-1:0] c0;
        int en_cycles;
        c0 = s_cnt;
        en_cycles = 0;
        bp_en = 1'b0;
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pc = 32'h100 + 32'(4 * i);
            tick();
            if (s_en === 1'b1) en_cycles++;
        end
        n_checks++;
        if (en_cycles != 10) begin n_errors++; $display("FAIL run_enabled: %0d enabled cycles required 10", en_cycles); end
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        n_checks++;
        if (s_en !== 1'b1 || s_state !== 2'd2) begin n_errors++; $display("FAIL halt_cycle: cpu_en %0b state %0d required 1 2", s_en, s_state); end
        tick();
        n_checks++;
        if (s_state !== 2'd1 || s_en !== 1'b0 || s_cnt !== c0 + 11) begin
            n_errors++; $display("FAIL run_halt_end: state %0d cpu_en %0b cycle_cnt %0d required 1 0 %0d", s_state, s_en, s_cnt, c0 + 11);
        end
    endtask

    task automatic test_breakpoint();
        logic [CNT_W-1:0] c1;
        bp_en = 1'b1;
        bp_addr = 32'h10;
        pc = 32'h0;
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pc = 32'(4 * i);
            tick();
        end
        pc = 32'h10;
        tick();
        n_checks++;
        if (s_en !== 1'b0) begin n_errors++; $display("FAIL bp_hit_en: cpu_en %0b required 0", s_en); end
        tick();
        n_checks++;
        if (s_state !== 2'd1) begin n_errors++; $display("FAIL bp_halt: state %0d required 1", s_state); end
        c1 = s_cnt;
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        tick();
        n_checks++;
        if (s_en !== 1'b1 || s_state !== 2'd2) begin n_errors++; $display("FAIL bp_resume: cpu_en %0b state %0d required 1 2", s_en, s_state); end
        pc = 32'h14;
        tick();
        pc = 32'h10;
        tick();
        n_checks++;
        if (s_en !== 1'b0) begin n_errors++; $display("FAIL bp_rehit: cpu_en %0b required 0", s_en); end
        tick();
        n_checks++;
        if (s_state !== 2'd1 || s_cnt !== c1 + 2) begin
            n_errors++; $display("FAIL bp_rehit_end: state %0d cycle_cnt %0d required 1 %0d", s_state, s_cnt, c1 + 2);
        end
        bp_en = 1'b0;
    endtask

    task automatic test_pro_sel();
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        tick();
        tick();
        pro_sel = 3'd3;
        tick();
        n_checks++;
        if (s_en !== 1'b0 || s_state !== 2'd2) begin n_errors++; $display("FAIL prosel_detect: cpu_en %0b state %0d required 0 2", s_en, s_state); end
        for (int i = 0; i < RST_CYCLES; i++) begin
            tick();
            n_checks++;
            if (s_state !== 2'd0 || s_rst !== 1'b1 || s_psq !== 3'd3 || s_cnt !== '0) begin
                n_errors++; $display("FAIL prosel_rstseq: state %0d cpu_rst %0b pro_sel_q %0d cnt %0d required 0 1 3 0", s_state, s_rst, s_psq, s_cnt);
            end
        end
        tick();
        n_checks++;
        if (s_state !== 2'd1) begin n_errors++; $display("FAIL prosel_halt: state %0d required 1", s_state); end
    endtask

    task automatic test_pro_sel_in_rstseq();
        int n_rs;
        pro_sel = 3'd6;
        tick();
        tick();
        tick();
        pro_sel = 3'd1;
        tick();
        n_rs = 0;
        for (int i = 0; i < 20 && s_state !== 2'd1; i++) begin
            tick();
            if (s_state === 2'd0) n_rs++;
        end
        n_checks++;
        if (n_rs != RST_CYCLES || s_state !== 2'd1 || s_psq !== 3'd1) begin
            n_errors++; $display("FAIL rstseq_restart: %0d reset cycles state %0d pro_sel_q %0d required %0d 1 1", n_rs, s_state, s_psq, RST_CYCLES);
        end
    endtask

    task automatic test_priority();
        logic [CNT_W-1:0] c2;
        int en_cycles;
        c2 = s_cnt;
        run_req = 1'b1; step_req = 1'b1; halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tick();
        run_req = 1'b0; step_req = 1'b0;
        n_checks++;
        if (s_state !== 2'd1 || s_en !== 1'b0) begin n_errors++; $display("FAIL prio_halt: state %0d cpu_en %0b required 1 0", s_state, s_en); end
        en_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (s_en === 1'b1) en_cycles++;
        end
        n_checks++;
        if (en_cycles != 1 || s_state !== 2'd1 || s_cnt !== c2 + 1) begin
            n_errors++; $display("FAIL prio_step: %0d enabled state %0d cnt %0d required 1 1 %0d", en_cycles, s_state, s_cnt, c2 + 1);
        end
    endtask

    task automatic test_back_to_back();
        step_req = 1'b1;
        tick();
        tick();
        n_checks++;
        if (s_state !== 2'd3 || s_en !== 1'b1) begin n_errors++; $display("FAIL b2b_step: state %0d cpu_en %0b required 3 1", s_state, s_en); end
        step_req = 1'b0;
        tick();
        n_checks++;
        if (s_state !== 2'd1) begin n_errors++; $display("FAIL b2b_drop: state %0d required 1", s_state); end
    endtask

    task automatic test_random();
        bp_addr = 32'h10;
        for (int i = 0; i < 400; i++) begin
            run_req  = ($urandom_range(0, 5) == 0);
            halt_req = ($urandom_range(0, 9) == 0);
            step_req = ($urandom_range(0, 7) == 0);
            bp_en    = $urandom_range(0, 1) == 1;
            pc       = 32'(4 * $urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0) pro_sel = 3'($urandom_range(0, 7));
            tick();
        end
        run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0; bp_en = 1'b0;
    endtask

    initial begin
        RST = 1'b1; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
        bp_en = 1'b0; bp_addr = '0; pc = '0; pro_sel = 3'd0;
        m_state = 2'd0; m_rc = 0; m_psq = 3'd0; m_cnt = '0; m_res = 1'b0;
        test_reset();
        test_step();
        test_run_halt();
        test_breakpoint();
        test_pro_sel();
        test_pro_sel_in_rstseq();
        test_priority();
        test_back_to_back();
        test_random();
        n_checks++;
        if (sb.size() != 0) begin n_errors++; $display("FAIL sb_leftover: %0d entries required 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
